// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device transmitter (inhibit, request, 11-bit
//               frame clocked by the device, ack check, inter-edge timeout)
// Revision    : 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev;
  logic [CNT_W-1:0]       cnt;
  logic [10:0]            shreg;
  logic [3:0]             bit_cnt;

  logic clk_sync;
  logic data_sync;
  logic fall;
  logic active;
  logic timeout_hit;

  assign clk_sync    = clk_sync_q[SYNC_STAGES-1];
  assign data_sync   = data_sync_q[SYNC_STAGES-1];
  assign fall        = clk_prev & ~clk_sync;
  assign active      = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout_hit = active && !fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle bus is high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev    <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
      clk_prev    <= clk_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      // One counter serves both the inhibit delay and the inter-edge watchdog.
      if (active) cnt <= fall ? '0 : cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg      <= {1'b1, ~^tx_data, tx_data};
            bit_cnt    <= '0;
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            ps2_data_oe <= 1'b1;
            cnt         <= '0;
            state       <= REQ;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REQ: begin
          ps2_clk_oe <= 1'b0;
          state      <= SEND;
        end
        SEND: begin
          if (fall) begin
            ps2_data_oe <= ~shreg[0];
            shreg       <= {1'b0, shreg[10:1]};
            bit_cnt     <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) state <= ACK;
          end
        end
        ACK: begin
          if (fall) begin
            if (data_sync) begin
              tx_err   <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            tx_done  <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (timeout_hit) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx_done     <= 1'b0;
        tx_err      <= 1'b1;
        tx_ready    <= 1'b1;
        busy        <= 1'b0;
        state       <= IDLE;
      end
    end
  end

endmodule
`default_nettype wire
